// File: rtl/aes128_pkg.sv
// Shared AES-128 key-schedule helpers: word/key types, RotWord and the
// round-constant table. The forward and inverse key expansions both use it.
package aes128_pkg;

    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned EXKEY_W    = 128 * (NUM_ROUNDS + 1);

    typedef logic [31:0]  word_t;
    typedef logic [127:0] key_t;
    typedef logic [3:0]   round_t;

    // Round key viewed as four words; w0 sits in the most significant bits.
    typedef struct packed {
        word_t w0;
        word_t w1;
        word_t w2;
        word_t w3;
    } key_words_t;

    // RotWord: rotate a word left by one byte.
    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Round constant for round r, placed in the top byte of the word.
    function automatic word_t rcon(input round_t r);
        word_t rc;
        rc = '0;
        case (r)
            4'd1:    rc[31:24] = 8'h01;
            4'd2:    rc[31:24] = 8'h02;
            4'd3:    rc[31:24] = 8'h04;
            4'd4:    rc[31:24] = 8'h08;
            4'd5:    rc[31:24] = 8'h10;
            4'd6:    rc[31:24] = 8'h20;
            4'd7:    rc[31:24] = 8'h40;
            4'd8:    rc[31:24] = 8'h80;
            4'd9:    rc[31:24] = 8'h1b;
            4'd10:   rc[31:24] = 8'h36;
            default: rc = '0;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes128_inv_keyex_if.sv
// Bus between the inverse key expansion and its user. The user side also
// supplies the shared S-box, which answers combinationally.
interface aes128_inv_keyex_if;
    import aes128_pkg::*;

    key_t                 i_key;
    logic                 i_key_en;
    logic [EXKEY_W-1:0]   o_exkey;
    logic                 o_key_ok;
    logic                 o_sbox_use;
    word_t                o_sbox_din;
    word_t                i_sbox_dout;

    modport master (
        output i_key, i_key_en, i_sbox_dout,
        input  o_exkey, o_key_ok, o_sbox_use, o_sbox_din
    );

    modport slave (
        input  i_key, i_key_en, i_sbox_dout,
        output o_exkey, o_key_ok, o_sbox_use, o_sbox_din
    );

endinterface

// File: rtl/aes128_inv_keystep.sv
// One inverse key-schedule round: rk(r) -> rk(r-1). Purely combinational;
// the S-box lookup is done outside on sbox_din and returned on sbox_dout.
module aes128_inv_keystep
    import aes128_pkg::*;
(
    input  key_t   key_in,
    input  round_t round,
    input  word_t  sbox_dout,
    output key_t   key_out,
    output word_t  sbox_din
);

    key_words_t w;
    key_words_t p;

    // Undo the XOR chain of the forward schedule, then recover w0 of rk(r-1).
    always_comb begin
        // NOTE: every variable driven here gets a value on every path first, so no latch is inferred.
        w    = key_in;
        p    = '0;
        p.w3 = w.w3 ^ w.w2;
        p.w2 = w.w2 ^ w.w1;
        p.w1 = w.w1 ^ w.w0;
        p.w0 = w.w0 ^ sbox_dout ^ rcon(round);
    end

    assign key_out  = p;
    assign sbox_din = rot_word(p.w3);

endmodule

// File: rtl/aes128_inv_keyex.sv
// Inverse AES-128 key expansion: starting from the last round key rk10,
// walks back one round per cycle and fills all eleven round-key slots.
module aes128_inv_keyex
    import aes128_pkg::*;
#(
    parameter int DLY = 1  // simulation register delay; register updates here are zero-delay
)
(
    input  logic              i_clk,
    input  logic              i_rst,
    aes128_inv_keyex_if.slave bus
);

    if (DLY < 0) begin : g_bad_dly
        $error("aes128_inv_keyex: DLY must be non-negative");
    end

    key_t                       key_r;
    round_t                     cnt_r;
    logic                       key_ok_r;
    logic [NUM_ROUNDS:0][127:0] exkey_r;   // element i holds rk(10-i)

    logic   step_en;
    round_t step_round;
    key_t   step_in;
    key_t   step_out;
    word_t  sbox_din;
    round_t wr_slot;

    // Select the round being undone this cycle and where its result lands.
    always_comb begin
        step_en    = bus.i_key_en | (cnt_r != 4'd0);
        step_round = bus.i_key_en ? 4'd10 : cnt_r;
        step_in    = bus.i_key_en ? bus.i_key : key_r;
        wr_slot    = 4'd11 - step_round;
    end

    aes128_inv_keystep u_step (
        .key_in    (step_in),
        .round     (step_round),
        .sbox_dout (bus.i_sbox_dout),
        .key_out   (step_out),
        .sbox_din  (sbox_din)
    );

    // Working key, round counter, round-key slots and the done flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the slot array is cleared on reset because the outputs must read as zero afterwards.
            key_r    <= '0;
            cnt_r    <= '0;
            key_ok_r <= 1'b0;
            exkey_r  <= '0;
        end else if (bus.i_key_en) begin
            // NOTE: non-blocking assignments keep every register reading its pre-edge value.
            key_r      <= step_out;
            cnt_r      <= 4'd9;
            key_ok_r   <= 1'b0;
            exkey_r[0] <= bus.i_key;
            exkey_r[1] <= step_out;
        end else if (cnt_r != 4'd0) begin
            key_r            <= step_out;
            cnt_r            <= cnt_r - 4'd1;
            exkey_r[wr_slot] <= step_out;
            if (cnt_r == 4'd1) begin
                key_ok_r <= 1'b1;
            end
        end
    end

    assign bus.o_exkey    = exkey_r;
    assign bus.o_key_ok   = key_ok_r & ~bus.i_key_en & ~i_rst;
    assign bus.o_sbox_use = step_en & ~i_rst;
    assign bus.o_sbox_din = sbox_din;

endmodule

// File: tb/tb_aes128_inv_keyex.sv
// Bench for aes128_inv_keyex: a reference S-box built from GF(2^8)
// arithmetic, a software forward key expansion as the model, directed
// scenarios and a random cross-check.
module tb_aes128_inv_keyex;
    import aes128_pkg::*;

    typedef logic [10:0][127:0] ks_t;   // ks[r] = rk r

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes128_inv_keyex_if bus ();

    aes128_inv_keyex #(.DLY(1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int use_cnt = 0;

    logic [7:0]  sbox_tab [0:255];
    bit          sbox_rand = 1'b0;
    logic [31:0] rand_dout = '0;

    // Model state: expansion of the run in progress and edges since its start.
    ks_t  m_pend = '0;
    ks_t  m_cur;
    logic m_zero;
    int   m_edges;

    localparam logic [127:0] FIPS_RK0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    // FIPS-197 forward key expansion.
    function automatic ks_t expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        ks_t         ks;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    function automatic logic [127:0] slot_of(input logic [1407:0] ex, input int r);
        return ex[128*(10-r) +: 128];
    endfunction

    // External S-box: reference table, or noise while the block is idle.
    assign bus.i_sbox_dout = sbox_rand ? rand_dout : sub_word(bus.o_sbox_din);

    // Model time base: a start strobe restarts the edge count, reset zeroes everything.
    always @(posedge clk) begin
        if (rst) begin
            m_zero  <= 1'b1;
            m_edges <= 0;
        end else if (bus.i_key_en) begin
            m_zero  <= 1'b0;
            m_cur   <= m_pend;
            m_edges <= 1;
        end else if (m_edges != 0 && m_edges < 10) begin
            m_edges <= m_edges + 1;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    task automatic compare_cycle();
        logic        en;
        logic        exp_use;
        logic        exp_ok;
        int          rr;
        logic [31:0] p3;
        en      = bus.i_key_en;
        exp_use = !rst && (en || (!m_zero && m_edges >= 1 && m_edges <= 9));
        exp_ok  = !rst && !en && !m_zero && m_edges == 10;
        check("key_ok", bus.o_key_ok, exp_ok);
        check("sbox_use", bus.o_sbox_use, exp_use);
        for (int r = 0; r <= 10; r++) begin
            if (m_zero)
                check($sformatf("slot_rk%0d", r), slot_of(bus.o_exkey, r), '0);
            else if (r >= 10 - m_edges)
                check($sformatf("slot_rk%0d", r), slot_of(bus.o_exkey, r), m_cur[r]);
        end
        if (exp_use) begin
            rr = en ? 10 : 10 - m_edges;
            p3 = en ? m_pend[rr-1][31:0] : m_cur[rr-1][31:0];
            check("sbox_din", bus.o_sbox_din, {p3[23:0], p3[31:24]});
        end
        if (bus.o_sbox_use) use_cnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [127:0] rk0);
        m_pend       = expand(rk0);
        bus.i_key    = m_pend[10];
        bus.i_key_en = 1'b1;
    endtask

    task automatic full_run(input logic [127:0] rk0);
        start(rk0);
        tick();
        bus.i_key_en = 1'b0;
        repeat (9) tick();
    endtask

    initial begin
        logic [7:0]    inv;
        logic [1407:0] snap;
        ks_t           ks;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        // Literal pins on the model itself.
        check("sbox_00", sbox_tab[8'h00], 8'h63);
        check("sbox_53", sbox_tab[8'h53], 8'hed);
        ks = expand(FIPS_RK0);
        check("model_fips_rk10", ks[10], FIPS_RK10);
        check("model_fips_rk9", ks[9], FIPS_RK9);
        ks = expand('0);
        check("model_zero_rk10", ks[10], ZERO_RK10);

        // Reset.
        rst          = 1'b1;
        bus.i_key    = '0;
        bus.i_key_en = 1'b0;
        @(posedge clk);
        #1;
        check("rst_exkey_zero", 128'(bus.o_exkey == '0), 128'd1);
        check("rst_key_ok", bus.o_key_ok, 1'b0);
        check("rst_sbox_use", bus.o_sbox_use, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // FIPS-197 vector.
        use_cnt = 0;
        start(FIPS_RK0);
        tick();
        bus.i_key_en = 1'b0;
        check("fips_rk9_edge1", slot_of(bus.o_exkey, 9), FIPS_RK9);
        check("fips_rk10_edge1", slot_of(bus.o_exkey, 10), FIPS_RK10);
        repeat (8) tick();
        check("fips_ok_edge9", bus.o_key_ok, 1'b0);
        tick();
        check("fips_ok_edge10", bus.o_key_ok, 1'b1);
        check("fips_rk0", slot_of(bus.o_exkey, 0), FIPS_RK0);
        repeat (3) tick();
        check("fips_use_cycles", use_cnt, 10);

        // Idle: S-box output must be ignored and slots must hold.
        snap      = bus.o_exkey;
        sbox_rand = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_dout = $urandom;
            tick();
        end
        check("idle_exkey_stable", 128'(bus.o_exkey == snap), 128'd1);
        check("idle_sbox_use", bus.o_sbox_use, 1'b0);
        sbox_rand = 1'b0;

        // Zero-key vector.
        full_run('0);
        check("zero_rk0", slot_of(bus.o_exkey, 0), '0);
        check("zero_rk10", slot_of(bus.o_exkey, 10), ZERO_RK10);
        tick();

        // Restart at step 5 with the FIPS vector.
        start('0);
        tick();
        bus.i_key_en = 1'b0;
        repeat (3) tick();
        start(FIPS_RK0);
        tick();
        bus.i_key_en = 1'b0;
        repeat (8) tick();
        check("restart_ok_edge9", bus.o_key_ok, 1'b0);
        tick();
        check("restart_rk0", slot_of(bus.o_exkey, 0), FIPS_RK0);
        check("restart_ok_done", bus.o_key_ok, 1'b1);
        tick();

        // Reset at step 4, then a normal FIPS run.
        start('0);
        tick();
        bus.i_key_en = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_exkey_zero", 128'(bus.o_exkey == '0), 128'd1);
        check("midrst_key_ok", bus.o_key_ok, 1'b0);
        check("midrst_sbox_use", bus.o_sbox_use, 1'b0);
        tick();
        full_run(FIPS_RK0);
        check("postrst_rk0", slot_of(bus.o_exkey, 0), FIPS_RK0);
        check("postrst_ok", bus.o_key_ok, 1'b1);

        // Random cross-check against the forward expansion.
        for (int n = 0; n < 1000; n++) begin
            full_run({$urandom, $urandom, $urandom, $urandom});
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes128_inv_keyex.md
AES128_INV_KEYEX -- requirements
Module: aes128_inv_keyex

Interface
REQ-001 Parameter: DLY, 1, simulation-only register update delay; it SHALL NOT affect synthesis.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 i_clk  input  1  rising-edge clock.
REQ-004 i_rst  input  1  synchronous active-high reset.
REQ-005 i_key  input  128  last round key rk10; w0 = [127:96], w3 = [31:0].
REQ-006 i_key_en  input  1  single-cycle start strobe; i_key is valid in the same cycle.
REQ-007 o_exkey  output  1408  all round keys; rk(r) = bits [128*(10-r)+127 : 128*(10-r)], so rk0 = [1407:1280] and rk10 = [127:0].
REQ-008 o_key_ok  output  1  all round keys valid.
REQ-009 o_sbox_use  output  1  external shared S-box requested this cycle.
REQ-010 o_sbox_din  output  32  four S-box input bytes.
REQ-011 i_sbox_dout  input  32  combinational S-box result, valid in the same cycle as o_sbox_din.

Function
REQ-012 Each step SHALL map rk(r) = {w0,w1,w2,w3} to rk(r-1) = {p0,p1,p2,p3}:
  - p3 = w3^w2
  - p2 = w2^w1
  - p1 = w1^w0
  - p0 = w0 ^ i_sbox_dout ^ rcon(r)
REQ-013 o_sbox_din SHALL equal {p3[23:0], p3[31:24]}, i.e. p3 rotated left by one byte.
REQ-014 rcon(r) SHALL occupy byte [31:24] with bytes [23:0] zero:
  - r = 1..8: 01, 02, 04, 08, 10, 20, 40, 80
  - r = 9: 1B
  - r = 10: 36
  - any other r: 0
REQ-015 The step input SHALL be i_key while i_key_en = 1, and the working key register otherwise.
REQ-016 A round counter SHALL run as follows:
  - i_key_en = 1: the step uses r = 10 and the counter loads 9.
  - Each following cycle with counter r != 0: the step uses r and the counter decrements.
  - The counter stays at 0 when idle.
REQ-017 A computation SHALL take exactly 10 step cycles: the i_key_en cycle plus 9 more.
REQ-018 rk9 SHALL be registered at the first clock edge and rk0 at the tenth.
REQ-019 o_sbox_use SHALL be 1 exactly in the step cycles (i_key_en = 1 or counter != 0) and 0 otherwise.
REQ-020 rk10 SHALL be captured into o_exkey[127:0] in the i_key_en cycle.
REQ-021 Each rk(r-1) SHALL be written to its slot at the end of its step cycle.
REQ-022 o_key_ok SHALL rise in the cycle after the step with r = 1 and hold until the next i_key_en or reset.
REQ-023 o_key_ok SHALL be gated low combinationally while i_key_en = 1.
REQ-024 An i_key_en during a computation SHALL abort it and restart from the new i_key; stale slots are don't-care until o_key_ok.
REQ-025 i_key_en held high for several cycles SHALL restart every cycle; the sequence proceeds from the last high cycle.
REQ-026 When idle, o_exkey SHALL be stable and i_sbox_dout SHALL be ignored.

Reset
REQ-027 While i_rst = 1, the working key, all o_exkey slots and the counter SHALL clear to 0, o_key_ok SHALL be 0, and o_sbox_use SHALL be 0.
REQ-028 Reset mid-operation SHALL abandon the computation.
REQ-029 i_rst SHALL take priority over a simultaneous i_key_en.

Structure
REQ-030 The rcon table and the byte-rotate function SHALL live in the shared package aes128_pkg, which is also used by the forward key expansion.
REQ-031 The one-round inverse transform of REQ-012/013 SHALL be a combinational sub-module, aes128_inv_keystep.
REQ-032 The RTL SHALL be 120-400 lines.

Verification
REQ-033 The bench SHALL pair the block with a reference combinational AES S-box. Directed scenarios:
  - FIPS-197 vector: i_key = d014f9a8c9ee2589e13f0cc8b6630ca6 with a 1-cycle i_key_en -> rk9 = ac7766f319fadc2128d12941575c006e after edge 1; o_key_ok = 1 after edge 10; rk0 = 2b7e151628aed2a6abf7158809cf4f3c; o_sbox_use high for exactly 10 cycles.
  - Zero-key vector: i_key = b4ef5bcb3e92e21123e951cf6f8f188e -> rk0 = 0; all 11 slots match a software forward expansion of key 0.
  - Restart: i_key_en with the zero-key vector, then at step 5 i_key_en with the FIPS vector -> FIPS rk0 after 10 more edges; o_key_ok stays 0 throughout.
  - Reset mid-run: i_rst at step 4 -> o_exkey = 0, o_key_ok = 0, o_sbox_use = 0 on the next cycle; then the FIPS run completes normally.
  - Idle: after o_key_ok, drive random i_sbox_dout for 20 cycles -> o_exkey unchanged, o_sbox_use = 0.
  - Cross-check: 1000 random keys forward-expanded in software; rk10 input -> all 11 round keys match.
